pmem_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) once the core moves to a multi-cycle datapath. Each requester has its own valid/ready request channel and a response pulse. The arbiter grants one transaction at a time, round-robin on ties, and holds it on the memory port until the response returns or a timeout fires. It sits between the IFU/LSU and the memory model that the control unit's load/store and byte-mask decode drive.

---
 rtl/pmem_arbiter_pkg.sv | 17 +
 rtl/pmem_arb_timer.sv | 41 ++++
 rtl/pmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg
// Shared encodings for the physical-memory port arbiter: FSM state codes
// and the owner codes that say which requester holds the memory port.
// Kept as plain localparam constants so the encodings stay bit-compatible
// with the older Verilog headers that use the same values.
package pmem_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;

    // Requester owning the current transaction
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/pmem_arb_timer.sv
// pmem_arb_timer
// Clearable, enabled up-counter used as the response timeout for the
// memory arbiter. The terminal-count output is high when the count equals
// TIMEOUT-1, so with the counter cleared on entry to WAIT the terminal
// count lines up with the TIMEOUT-th WAIT cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear, wins over en
//   en     in   count enable
//   tc     out  count == TIMEOUT-1
module pmem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Counter: clear has priority so a fresh WAIT always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
// Shares one physical-memory port between the instruction-fetch unit (IFU)
// and the load/store unit (LSU). One transaction is in flight at a time:
// IDLE grants a requester (round-robin on ties), REQ presents the captured
// request to memory until accepted, WAIT routes the response (or a forced
// error response on timeout) back to the owner.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr IFU request channel
//   ifu_rsp_valid, ifu_rdata      IFU one-cycle response
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
//                                 LSU request channel
//   lsu_rsp_valid, lsu_rdata      LSU one-cycle response
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask
//                                 memory request channel
//   mem_rsp_valid, mem_rdata      memory response
//   busy                          FSM not in IDLE
//   err                           one-cycle pulse on timeout
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              owner;
    logic              last_owner;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_wen;
    logic [DATA_W-1:0] cap_wdata;
    logic [MASK_W-1:0] cap_wmask;

    logic              in_idle;
    logic              in_wait;
    logic              ifu_grant;
    logic              lsu_grant;
    logic              rsp_done;
    logic              timeout_hit;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;
    logic              timer_tc;

    assign in_idle = (state == ARB_IDLE);
    assign in_wait = (state == ARB_WAIT);

    // On a tie only the requester not served last sees ready
    assign ifu_req_ready = in_idle && (!lsu_req_valid || (last_owner == OWN_LSU));
    assign lsu_req_ready = in_idle && (!ifu_req_valid || (last_owner == OWN_IFU));

    assign ifu_grant = ifu_req_valid && ifu_req_ready;
    assign lsu_grant = lsu_req_valid && lsu_req_ready;

    // A real response in the terminal cycle beats the timeout
    assign rsp_done    = in_wait && mem_rsp_valid;
    assign timeout_hit = in_wait && !mem_rsp_valid && timer_tc;
    assign rsp_fire    = rsp_done || timeout_hit;
    assign rsp_data    = rsp_done ? mem_rdata : '0;

    assign ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
    assign lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
    assign ifu_rdata     = ifu_rsp_valid ? rsp_data : '0;
    assign lsu_rdata     = lsu_rsp_valid ? rsp_data : '0;
    assign err           = timeout_hit;

    assign mem_req_valid = (state == ARB_REQ);
    assign mem_addr      = cap_addr;
    assign mem_wen       = cap_wen;
    assign mem_wdata     = cap_wdata;
    assign mem_wmask     = cap_wmask;
    assign busy          = !in_idle;

    // Timeout counter restarts on the REQ->WAIT accept and only advances
    // while WAIT is still missing its response
    pmem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == ARB_REQ) && mem_req_ready),
        .en    (in_wait && !mem_rsp_valid),
        .tc    (timer_tc)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (ifu_grant || lsu_grant) state_next = ARB_REQ;
            ARB_REQ:  if (mem_req_ready)          state_next = ARB_WAIT;
            ARB_WAIT: if (rsp_fire)               state_next = ARB_IDLE;
            default:                              state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the granted request; IFU fetches are always plain reads so
    // the write fields are forced to zero for them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
            cap_addr   <= '0;
            cap_wen    <= 1'b0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
        end else if (lsu_grant) begin
            owner      <= OWN_LSU;
            last_owner <= OWN_LSU;
            cap_addr   <= lsu_addr;
            cap_wen    <= lsu_wen;
            cap_wdata  <= lsu_wdata;
            cap_wmask  <= lsu_wmask;
        end else if (ifu_grant) begin
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
            cap_addr   <= ifu_addr;
            cap_wen    <= 1'b0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
// Directed bench for pmem_arbiter (TIMEOUT = 4). Memory behaviour is
// driven by hand from the stimulus so every latency is explicit.
module tb_pmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        busy, err;

    int checks = 0;
    int errors = 0;

    pmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          accept_wait;
        int          rsp_wait;
        logic [31:0] mem_rd;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic        chk_rdata;
    } txn_t;

    typedef struct {
        logic ifu_v;
        logic lsu_v;
        logic exp_ifu_rdy;
        logic exp_lsu_rdy;
    } rdy_vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Leaves time at 2 units after a rising edge
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // One full transaction from IDLE back to IDLE
    task automatic applyStimulus(input txn_t t, input string tag);
        if (t.is_lsu) begin
            lsu_req_valid = 1'b1;
            lsu_addr  = t.addr;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr  = t.addr;
            lsu_addr  = ~t.addr;
        end
        lsu_wen   = t.wen;
        lsu_wdata = t.wdata;
        lsu_wmask = t.wmask;
        #1;
        checkOutput({tag, " ready"}, t.is_lsu ? lsu_req_ready : ifu_req_ready, 1);
        tick;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
        checkOutput({tag, " mem_req_valid"}, mem_req_valid, 1);
        checkOutput({tag, " mem_addr"}, mem_addr, t.addr);
        checkOutput({tag, " mem_wen"}, mem_wen, t.exp_wen);
        checkOutput({tag, " mem_wdata"}, mem_wdata, t.exp_wdata);
        checkOutput({tag, " mem_wmask"}, mem_wmask, t.exp_wmask);
        checkOutput({tag, " busy"}, busy, 1);
        checkOutput({tag, " readies in REQ"}, {ifu_req_ready, lsu_req_ready}, 0);
        for (int i = 0; i < t.accept_wait; i++) begin
            tick;
            #1;
            checkOutput({tag, " stall valid"}, mem_req_valid, 1);
            checkOutput({tag, " stall addr"}, mem_addr, t.addr);
            checkOutput({tag, " stall wdata"}, mem_wdata, t.exp_wdata);
        end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < t.rsp_wait; i++) begin
            #1;
            checkOutput({tag, " early rsp"}, {ifu_rsp_valid, lsu_rsp_valid}, 0);
            tick;
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = t.mem_rd;
        #1;
        checkOutput({tag, " owner rsp_valid"}, t.is_lsu ? lsu_rsp_valid : ifu_rsp_valid, 1);
        checkOutput({tag, " other rsp_valid"}, t.is_lsu ? ifu_rsp_valid : lsu_rsp_valid, 0);
        checkOutput({tag, " err"}, err, 0);
        if (t.chk_rdata)
            checkOutput({tag, " rdata"}, t.is_lsu ? lsu_rdata : ifu_rdata, t.mem_rd);
        tick;
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput({tag, " rsp after pulse"}, {ifu_rsp_valid, lsu_rsp_valid}, 0);
        checkOutput({tag, " idle busy"}, busy, 0);
    endtask

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t     txns[4];
        rdy_vec_t rdy[4];
        logic     tie_lsu[4];
        int       hs_cyc[5];
        int       rsp_cyc[5];
        int       hs_n;
        int       rsp_n;

        rdy[0] = '{ifu_v:1'b0, lsu_v:1'b0, exp_ifu_rdy:1'b1, exp_lsu_rdy:1'b1};
        rdy[1] = '{ifu_v:1'b1, lsu_v:1'b0, exp_ifu_rdy:1'b1, exp_lsu_rdy:1'b1};
        rdy[2] = '{ifu_v:1'b0, lsu_v:1'b1, exp_ifu_rdy:1'b0, exp_lsu_rdy:1'b1};
        rdy[3] = '{ifu_v:1'b1, lsu_v:1'b1, exp_ifu_rdy:1'b0, exp_lsu_rdy:1'b1};

        txns[0] = '{is_lsu:1'b0, addr:32'h8000_0000, wen:1'b1, wdata:32'hFFFF_FFFF,
                    wmask:8'hFF, accept_wait:0, rsp_wait:1, mem_rd:32'h0000_0413,
                    exp_wen:1'b0, exp_wdata:32'h0, exp_wmask:8'h00, chk_rdata:1'b1};
        txns[1] = '{is_lsu:1'b1, addr:32'h8000_1000, wen:1'b1, wdata:32'hDEAD_BEEF,
                    wmask:8'h0F, accept_wait:3, rsp_wait:0, mem_rd:32'h1234_5678,
                    exp_wen:1'b1, exp_wdata:32'hDEAD_BEEF, exp_wmask:8'h0F, chk_rdata:1'b0};
        txns[2] = '{is_lsu:1'b1, addr:32'h8000_2004, wen:1'b0, wdata:32'hA5A5_A5A5,
                    wmask:8'hF0, accept_wait:1, rsp_wait:2, mem_rd:32'hCAFE_F00D,
                    exp_wen:1'b0, exp_wdata:32'hA5A5_A5A5, exp_wmask:8'hF0, chk_rdata:1'b1};
        txns[3] = '{is_lsu:1'b0, addr:32'h8000_0004, wen:1'b0, wdata:32'h0,
                    wmask:8'h00, accept_wait:0, rsp_wait:2, mem_rd:32'h00A0_0093,
                    exp_wen:1'b0, exp_wdata:32'h0, exp_wmask:8'h00, chk_rdata:1'b1};

        tie_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;

        $display("[TB] reset state");
        checkOutput("reset mem_req_valid", mem_req_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        checkOutput("reset ifu_rdata", ifu_rdata, 0);
        checkOutput("reset lsu_rdata", lsu_rdata, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;

        for (int i = 0; i < 4; i++) begin
            ifu_req_valid = rdy[i].ifu_v;
            lsu_req_valid = rdy[i].lsu_v;
            #1;
            checkOutput($sformatf("ready vec%0d ifu", i), ifu_req_ready, rdy[i].exp_ifu_rdy);
            checkOutput($sformatf("ready vec%0d lsu", i), lsu_req_ready, rdy[i].exp_lsu_rdy);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        $display("[TB] transaction table");
        for (int i = 0; i < 4; i++) applyStimulus(txns[i], $sformatf("txn%0d", i));

        $display("[TB] tie arbitration");
        ifu_addr = 32'h1000_0000; lsu_addr = 32'h2000_0000;
        lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("tie%0d ifu_ready", k), ifu_req_ready, !tie_lsu[k]);
            checkOutput($sformatf("tie%0d lsu_ready", k), lsu_req_ready, tie_lsu[k]);
            tick;
            #1;
            checkOutput($sformatf("tie%0d mem_addr", k), mem_addr,
                        tie_lsu[k] ? 32'h2000_0000 : 32'h1000_0000);
            tick;
            #1;
            checkOutput($sformatf("tie%0d owner rsp", k),
                        tie_lsu[k] ? lsu_rsp_valid : ifu_rsp_valid, 1);
            checkOutput($sformatf("tie%0d other rsp", k),
                        tie_lsu[k] ? ifu_rsp_valid : lsu_rsp_valid, 0);
            tick;
        end
        lsu_req_valid = 1'b0;

        $display("[TB] minimum latency");
        hs_n = 0; rsp_n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ifu_req_valid && ifu_req_ready && hs_n < 5) begin
                hs_cyc[hs_n] = c; hs_n++;
            end
            if (ifu_rsp_valid && rsp_n < 5) begin
                rsp_cyc[rsp_n] = c; rsp_n++;
            end
            tick;
        end
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        checkOutput("minlat grant count", hs_n, 4);
        checkOutput("minlat rsp count", rsp_n, 4);
        if (hs_n >= 3 && rsp_n >= 1) begin
            checkOutput("minlat grant spacing 1", hs_cyc[1] - hs_cyc[0], 3);
            checkOutput("minlat grant spacing 2", hs_cyc[2] - hs_cyc[1], 3);
            checkOutput("minlat grant to rsp", rsp_cyc[0] - hs_cyc[0], 2);
        end

        $display("[TB] timeout");
        #1;
        checkOutput("timeout start idle", busy, 0);
        mem_req_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        ifu_addr = 32'h8000_0100; ifu_req_valid = 1'b1;
        tick;
        ifu_req_valid = 1'b0;
        #1;
        checkOutput("timeout req", mem_req_valid, 1);
        tick;
        for (int w = 1; w <= 3; w++) begin
            #1;
            checkOutput($sformatf("timeout wait%0d rsp", w), ifu_rsp_valid, 0);
            checkOutput($sformatf("timeout wait%0d err", w), err, 0);
            tick;
        end
        #1;
        checkOutput("timeout rsp_valid", ifu_rsp_valid, 1);
        checkOutput("timeout rdata", ifu_rdata, 0);
        checkOutput("timeout err", err, 1);
        checkOutput("timeout lsu rsp", lsu_rsp_valid, 0);
        tick;
        mem_rsp_valid = 1'b1;
        #1;
        checkOutput("stale busy", busy, 0);
        checkOutput("stale rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        checkOutput("stale err", err, 0);
        tick;
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;

        $display("[TB] reset mid-WAIT");
        lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        tick;
        lsu_req_valid = 1'b0;
        tick;
        #1;
        checkOutput("midreset busy before", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset mem_req_valid", mem_req_valid, 0);
        checkOutput("midreset rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        mem_req_ready = 1'b0;
        tick;
        #2;
        rst_n = 1'b1;
        tick;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        checkOutput("post reset rsp ignored", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        checkOutput("post reset busy", busy, 0);
        tick;
        mem_rsp_valid = 1'b0;
        applyStimulus(txns[3], "post reset fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
